osc_phase_gen: RTL and testbench
================================

Name: osc_phase_gen

Overview:
Phase-accumulator oscillator that sits directly upstream of the random sample-and-hold stage. It produces the 16-bit SAW ramp that the stage compares against 16'h8000 to trigger new noise samples. It also provides derived triangle and pulse waveforms, a wrap strobe and a hard-sync input. Frequency updates use a ready/valid handshake and take effect only on a sample tick, so the phase step never changes mid-sample.

Parameters:
ACC_W, 32, phase accumulator width (>= OUT_W+1)
OUT_W, 16, waveform output width
TICK_DIV, 4, CLK cycles per sample tick (>= 1; 1 = tick every cycle)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
LOCKED  in  1  clock-manager lock; when low, all state holds
FREQ  in  ACC_W  phase increment per tick
FREQ_VALID  in  1  FREQ is presented
FREQ_READY  out  1  new FREQ can be accepted
PW  in  OUT_W  pulse-width threshold for SQUARE
HARD_SYNC  in  1  force phase to zero
SAW  out  OUT_W  ramp = acc[ACC_W-1 -: OUT_W]
TRI  out  OUT_W  triangle
SQUARE  out  OUT_W  all-ones or all-zeros pulse
WRAP  out  1  one-cycle strobe on accumulator overflow

Behaviour:
- Reset (RESET=1 at a CLK edge, regardless of LOCKED):
  - acc, tick counter, active increment and pending increment all clear to 0; pending flag clears.
  - SAW = TRI = SQUARE = 0; WRAP = 0; FREQ_READY = 1.
  - Reset mid-operation discards any pending FREQ.
- LOCKED=0 (and RESET=0): the tick counter, acc, increments, outputs and handshake state all hold. WRAP is forced to 0. FREQ_VALID is ignored.
- Tick divider:
  - cnt counts 0..TICK_DIV-1 and wraps.
  - tick is asserted in the cycle where cnt == TICK_DIV-1.
- Frequency handshake:
  - FREQ_READY = ~pending.
  - FREQ_VALID && FREQ_READY: FREQ is captured into the pending register and pending is set.
  - FREQ_VALID while FREQ_READY=0 is ignored; there is no queueing.
- Phase update on a tick:
  - acc <= acc + inc_active (modulo 2^ACC_W). The carry-out sets WRAP=1 for the next cycle only.
  - Same edge: if pending=1, inc_active <= pending increment and pending clears. The new increment therefore applies from the following tick.
  - Capture and apply on the same tick edge is not possible, because capture requires READY.
- HARD_SYNC=1 (LOCKED=1):
  - acc <= 0 on that edge; the tick counter is unaffected.
  - If HARD_SYNC coincides with a tick, sync wins: acc=0 and WRAP stays 0. A pending increment is still applied on that tick.
- FREQ=0 freezes the phase. Full-scale wrap is exact modular arithmetic with no saturation.
- Outputs are registered from the acc value of the previous cycle (1-cycle latency from acc). Let top = acc[ACC_W-1 -: OUT_W]:
  - SAW = top.
  - TRI = acc[ACC_W-1] ? ~acc[ACC_W-2 -: OUT_W] : acc[ACC_W-2 -: OUT_W].
  - SQUARE = (top < PW) ? all-ones : 0. PW=0 gives constant 0.
- WRAP is asserted for exactly one CLK cycle per overflow.

Test Plan:
- Reset check: hold RESET=1 with LOCKED=1 for 3 cycles -> SAW=TRI=SQUARE=0, WRAP=0, FREQ_READY=1. Drive FREQ_VALID=1 during reset -> nothing captured.
- Ramp with TICK_DIV=4, FREQ=32'h4000_0000 loaded after reset:
  - READY drops, then returns to 1 at the next tick.
  - On the following ticks SAW steps 0000 -> 4000 -> 8000 -> C000 -> 0000, each step 4 cycles apart.
  - WRAP pulses for 1 cycle at the C000 -> 0000 step.
- Handshake ignore: with pending set, drive FREQ_VALID with FREQ=32'h1000_0000 -> not captured. After the tick, READY=1 and the step size is still the first value.
- Sync priority: assert HARD_SYNC in a tick cycle where acc=C000_0000 with FREQ=4000_0000 -> acc=0 and no WRAP pulse. The next tick gives SAW=4000.
- LOCKED gating: drop LOCKED for 10 cycles mid-ramp -> SAW, tick phase and READY frozen. Resume -> the ramp continues from the held value with the same remaining tick spacing.
- Waveform decode with PW=16'h8000:
  - acc=4000_0000 -> TRI=8000, SQUARE=FFFF.
  - acc=C000_0000 -> TRI=7FFF, SQUARE=0000.

Source files
------------

// File: rtl/osc_phase_gen.sv
// Phase-accumulator oscillator: SAW/TRI/pulse outputs, wrap strobe, hard sync.
// The phase step only changes on a sample tick, so it never changes mid-sample.
module osc_phase_gen #(
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 16,
  parameter int TICK_DIV = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOCKED,
  input  logic [ACC_W-1:0] FREQ,
  input  logic             FREQ_VALID,
  output logic             FREQ_READY,
  input  logic [OUT_W-1:0] PW,
  input  logic             HARD_SYNC,
  output logic [OUT_W-1:0] SAW,
  output logic [OUT_W-1:0] TRI,
  output logic [OUT_W-1:0] SQUARE,
  output logic             WRAP
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_active;
  logic [ACC_W-1:0] inc_pend;
  logic             pending;
  logic             wrap_q;
  logic             tick;
  logic [ACC_W:0]   sum;
  logic [OUT_W-1:0] top;
  logic [OUT_W-1:0] low;

  assign tick = (cnt == CNT_MAX);
  assign sum  = {1'b0, acc} + {1'b0, inc_active};
  assign top  = acc[ACC_W-1 -: OUT_W];
  assign low  = acc[ACC_W-2 -: OUT_W];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt        <= '0;
      acc        <= '0;
      inc_active <= '0;
      inc_pend   <= '0;
      pending    <= 1'b0;
      wrap_q     <= 1'b0;
      SAW        <= '0;
      TRI        <= '0;
      SQUARE     <= '0;
    end else if (LOCKED) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);

      // sync beats a coincident tick: no wrap strobe on a forced restart
      if (HARD_SYNC) begin
        acc    <= '0;
        wrap_q <= 1'b0;
      end else if (tick) begin
        acc    <= sum[ACC_W-1:0];
        wrap_q <= sum[ACC_W];
      end else begin
        wrap_q <= 1'b0;
      end

      // capture needs !pending and apply needs pending, so these never collide
      if (FREQ_VALID && !pending) begin
        inc_pend <= FREQ;
        pending  <= 1'b1;
      end else if (tick && pending) begin
        inc_active <= inc_pend;
        pending    <= 1'b0;
      end

      SAW    <= top;
      TRI    <= acc[ACC_W-1] ? ~low : low;
      SQUARE <= {OUT_W{top < PW}};
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign FREQ_READY = ~pending;
  assign WRAP       = wrap_q & LOCKED;

endmodule

// File: tb/tb_osc_phase_gen.sv
// Directed bench for osc_phase_gen: reset, ramp, handshake, lock gating, sync, decode.
module tb_osc_phase_gen;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        LOCKED;
  logic [31:0] FREQ;
  logic        FREQ_VALID;
  logic        FREQ_READY;
  logic [15:0] PW;
  logic        HARD_SYNC;
  logic [15:0] SAW;
  logic [15:0] TRI;
  logic [15:0] SQUARE;
  logic        WRAP;

  int n_assert = 0;
  int n_fail   = 0;

  osc_phase_gen #(.ACC_W(32), .OUT_W(16), .TICK_DIV(4)) dut (
    .CLK(CLK), .RESET(RESET), .LOCKED(LOCKED), .FREQ(FREQ),
    .FREQ_VALID(FREQ_VALID), .FREQ_READY(FREQ_READY), .PW(PW),
    .HARD_SYNC(HARD_SYNC), .SAW(SAW), .TRI(TRI), .SQUARE(SQUARE), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; LOCKED = 1'b1; FREQ = 32'h4000_0000; FREQ_VALID = 1'b1;
    PW = 16'h8000; HARD_SYNC = 1'b0;

    // reset held 3 cycles with VALID high
    cyc(3);
    check("rst_saw",    SAW,        0);
    check("rst_tri",    TRI,        0);
    check("rst_square", SQUARE,     0);
    check("rst_wrap",   WRAP,       0);
    check("rst_ready",  FREQ_READY, 1);

    // load 4000_0000, then try 1000_0000 while pending
    RESET = 1'b0;
    cyc(1);                                   // P1: capture
    check("ready_drop", FREQ_READY, 0);
    FREQ = 32'h1000_0000;
    cyc(1);                                   // P2
    check("ready_hold2", FREQ_READY, 0);
    cyc(1);                                   // P3
    check("ready_hold3", FREQ_READY, 0);
    FREQ_VALID = 1'b0;
    cyc(1);                                   // P4: tick applies increment
    check("ready_back", FREQ_READY, 1);
    check("saw_p4",     SAW,        0);
    cyc(4);                                   // P8: acc=4000_0000
    check("saw_lag",    SAW,        0);
    cyc(1);                                   // P9
    check("saw_4000",   SAW,        16'h4000);
    check("tri_4000",   TRI,        16'h8000);
    check("sq_4000",    SQUARE,     16'hFFFF);
    cyc(3);                                   // P12: acc=8000_0000
    check("saw_p12",    SAW,        16'h4000);
    cyc(1);                                   // P13
    check("saw_8000",   SAW,        16'h8000);
    check("tri_8000",   TRI,        16'hFFFF);
    check("sq_8000",    SQUARE,     16'h0000);

    // lock gating for 10 cycles, VALID ignored
    LOCKED = 1'b0; FREQ_VALID = 1'b1; FREQ = 32'h1000_0000;
    cyc(10);
    check("lock_saw",   SAW,        16'h8000);
    check("lock_ready", FREQ_READY, 1);
    check("lock_wrap",  WRAP,       0);
    LOCKED = 1'b1; FREQ_VALID = 1'b0;
    cyc(3);                                   // tick resumes after remaining 3 cycles
    check("resume_saw", SAW,        16'h8000);
    cyc(1);
    check("saw_c000",   SAW,        16'hC000);
    check("tri_c000",   TRI,        16'h7FFF);
    check("sq_c000",    SQUARE,     16'h0000);
    cyc(2);
    check("wrap_pre",   WRAP,       0);
    cyc(1);                                   // wrap tick
    check("wrap_on",    WRAP,       1);
    cyc(1);
    check("wrap_off",   WRAP,       0);
    check("saw_wrap0",  SAW,        16'h0000);

    // hard sync on the tick where acc=C000_0000
    cyc(14);
    HARD_SYNC = 1'b1;
    cyc(1);
    check("sync_wrap",  WRAP,       0);
    check("sync_saw_c", SAW,        16'hC000);
    HARD_SYNC = 1'b0;
    cyc(1);
    check("sync_saw0",  SAW,        16'h0000);
    check("sync_wrap2", WRAP,       0);
    cyc(3);
    check("sync_lag",   SAW,        16'h0000);
    cyc(1);
    check("sync_next",  SAW,        16'h4000);

    PW = 16'h0000;
    cyc(1);
    check("pw0_square", SQUARE,     16'h0000);

    // reset mid-operation discards a pending FREQ
    FREQ_VALID = 1'b1; FREQ = 32'h1000_0000;
    cyc(1);
    check("pend_set",   FREQ_READY, 0);
    FREQ_VALID = 1'b0; RESET = 1'b1;
    cyc(1);
    check("rst2_ready", FREQ_READY, 1);
    check("rst2_saw",   SAW,        0);
    RESET = 1'b0;
    cyc(8);
    check("rst2_frozen", SAW,       0);
    check("rst2_ready2", FREQ_READY, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
